// File: rtl/avg_decim_filter_mc.sv
// Multi-channel boxcar averager with per-channel pre-decimation.
// Optional build macro AVG_ROUND_EN: round half up and saturate instead of floor.
module avg_decim_filter_mc #(
   parameter int DATA_W = 28,
   parameter int NUM_CH = 4,
   parameter int LOG2_N = 10,
   parameter int DECIM  = 4,
   localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clock_in,
   input  logic              reset,
   input  logic              enable,
   input  logic              clear,
   input  logic              in_valid,
   input  logic [CW-1:0]     in_channel,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [CW-1:0]     out_channel,
   output logic [DATA_W-1:0] out_data,
   output logic              out_drop
);

   localparam int DCW = $clog2(DECIM) + 1;
   localparam int AW  = DATA_W + LOG2_N;

   logic [DCW-1:0]           dcnt [NUM_CH];
   logic [LOG2_N-1:0]        scnt [NUM_CH];
   logic signed [AW-1:0]     acc  [NUM_CH];

   logic signed [DATA_W-1:0] sample;
   logic                     ch_ok;
   logic [CW-1:0]            sel;
   logic                     keep;
   logic                     last;
   logic signed [AW-1:0]     sum;
   logic [DATA_W-1:0]        avg;

`ifdef AVG_ROUND_EN
   localparam int RW = AW + 1;
   localparam logic signed [RW-1:0] SAT_MAX = {{(RW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   logic signed [RW-1:0]     rsum;
`endif

   assign sample = in_data;

   always_comb begin
      ch_ok = {1'b0, in_channel} < (CW+1)'(NUM_CH);
      // out-of-range tags read channel 0 harmlessly; the result is never used
      sel   = ch_ok ? in_channel : '0;
      keep  = dcnt[sel] == DCW'(DECIM - 1);
      last  = scnt[sel] == '1;
      sum   = acc[sel] + AW'(sample);
`ifdef AVG_ROUND_EN
      rsum = {sum[AW-1], sum};
      rsum = rsum + (RW'(1) <<< (LOG2_N - 1));
      if ((rsum >>> LOG2_N) > SAT_MAX)
         avg = {1'b0, {(DATA_W-1){1'b1}}};
      else
         avg = DATA_W'(rsum >>> LOG2_N);
`else
      avg = DATA_W'(sum >>> LOG2_N);
`endif
   end

   always_ff @(posedge clock_in) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            dcnt[i] <= '0;
            scnt[i] <= '0;
            acc[i]  <= '0;
         end
         out_valid   <= 1'b0;
         out_channel <= '0;
         out_data    <= '0;
         out_drop    <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         out_drop  <= 1'b0;
         if (enable) begin
            if (clear) begin
               for (int unsigned i = 0; i < NUM_CH; i++) begin
                  dcnt[i] <= '0;
                  scnt[i] <= '0;
                  acc[i]  <= '0;
               end
            end else if (in_valid) begin
               if (!ch_ok) begin
                  out_drop <= 1'b1;
               end else if (!keep) begin
                  dcnt[sel] <= dcnt[sel] + DCW'(1);
               end else begin
                  dcnt[sel] <= '0;
                  if (last) begin
                     acc[sel]    <= '0;
                     scnt[sel]   <= '0;
                     out_valid   <= 1'b1;
                     out_channel <= in_channel;
                     out_data    <= avg;
                  end else begin
                     acc[sel]  <= sum;
                     scnt[sel] <= scnt[sel] + LOG2_N'(1);
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_avg_decim_filter_mc.sv
// Self-checking bench for avg_decim_filter_mc: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based block-average model.
module tb_avg_decim_filter_mc;

   localparam int DATA_W = 16;
   localparam int NUM_CH = 3;
   localparam int LOG2_N = 2;
   localparam int DECIM  = 3;
   localparam int CW     = 2;
   localparam int N      = 4;

   logic              clock_in = 1'b0;
   logic              reset, enable, clear, in_valid;
   logic [CW-1:0]     in_channel;
   logic [DATA_W-1:0] in_data;
   logic              out_valid, out_drop;
   logic [CW-1:0]     out_channel;
   logic [DATA_W-1:0] out_data;

   avg_decim_filter_mc #(
      .DATA_W(DATA_W), .NUM_CH(NUM_CH), .LOG2_N(LOG2_N), .DECIM(DECIM)
   ) dut (
      .clock_in(clock_in), .reset(reset), .enable(enable), .clear(clear),
      .in_valid(in_valid), .in_channel(in_channel), .in_data(in_data),
      .out_valid(out_valid), .out_channel(out_channel), .out_data(out_data),
      .out_drop(out_drop)
   );

   always #5 clock_in = ~clock_in;

   int checks = 0;
   int errors = 0;

   // reference model: valid-sample count and pending kept samples per channel
   int vcount [NUM_CH];
   int kept   [NUM_CH][$];
   logic              exp_valid, exp_drop;
   logic [CW-1:0]     exp_ch   = '0;
   logic [DATA_W-1:0] exp_data = '0;

   // observation log used by scenario-level checks
   int cyc = 0;
   int pulses;
   int ch_pulses [4];
   int results [$];
   int pulse_cyc [$];
   int drops;

   function automatic int block_avg(input int s[$]);
      longint sum = 0;
      longint q;
      foreach (s[i]) sum += s[i];
`ifdef AVG_ROUND_EN
      sum += N / 2;
`endif
      q = sum / N;
      if ((sum % N) != 0 && sum < 0) q -= 1;
`ifdef AVG_ROUND_EN
      if (q > (longint'(1) << (DATA_W - 1)) - 1) q = (longint'(1) << (DATA_W - 1)) - 1;
`endif
      return int'(q);
   endfunction

   task automatic clear_log();
      pulses = 0; drops = 0;
      foreach (ch_pulses[i]) ch_pulses[i] = 0;
      results.delete(); pulse_cyc.delete();
   endtask

   task automatic cycle(input logic rst, input logic en, input logic clr, input logic v,
                        input int ch, input int d);
      reset = rst; enable = en; clear = clr; in_valid = v;
      in_channel = CW'(ch); in_data = DATA_W'(d);
      exp_valid = 1'b0; exp_drop = 1'b0;
      if (rst) begin
         foreach (vcount[i]) begin vcount[i] = 0; kept[i].delete(); end
         exp_ch = '0; exp_data = '0;
      end else if (en && clr) begin
         foreach (vcount[i]) begin vcount[i] = 0; kept[i].delete(); end
      end else if (en && v) begin
         if (ch >= NUM_CH) exp_drop = 1'b1;
         else begin
            vcount[ch]++;
            if (vcount[ch] % DECIM == 0) begin
               kept[ch].push_back(d);
               if (kept[ch].size() == N) begin
                  exp_valid = 1'b1;
                  exp_ch    = CW'(ch);
                  exp_data  = DATA_W'(block_avg(kept[ch]));
                  kept[ch].delete();
               end
            end
         end
      end
      @(posedge clock_in); #1;
      cyc++;
      if (out_valid) begin
         pulses++; ch_pulses[out_channel]++;
         results.push_back(int'($signed(out_data)));
         pulse_cyc.push_back(cyc);
      end
      if (out_drop) drops++;
   endtask

   task automatic test_reset();
      cycle(1, 1, 0, 0, 0, 0);
      cycle(1, 1, 0, 1, 3, 5);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
      checks++; if (out_drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %b exp 0", out_drop); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", out_data); end
      checks++; if (out_channel !== '0) begin errors++; $display("FAIL reset_channel got %0d exp 0", out_channel); end
   endtask

   task automatic test_block_average();
      clear_log();
      for (int i = 0; i < N * DECIM; i++) begin
         cycle(0, 1, 0, 1, 0, 1000);
         checks++; if (out_valid !== exp_valid || out_drop !== exp_drop) begin errors++;
            $display("FAIL block_avg strobes cyc %0d got v%b d%b exp v%b d%b", i, out_valid, out_drop, exp_valid, exp_drop); end
         checks++; if (out_data !== exp_data || out_channel !== exp_ch) begin errors++;
            $display("FAIL block_avg result cyc %0d got ch%0d %h exp ch%0d %h", i, out_channel, out_data, exp_ch, exp_data); end
      end
      checks++; if (pulses != 1 || pulse_cyc.size() != 1 || results[0] != 1000) begin errors++;
         $display("FAIL block_avg_single got %0d pulses exp 1 of 1000", pulses); end
   endtask

   task automatic test_floor_negative();
      int vals [4];
      int want;
      vals = '{-1, -1, -1, -2};
`ifdef AVG_ROUND_EN
      want = -1;
`else
      want = -2;
`endif
      clear_log();
      foreach (vals[k])
         for (int r = 0; r < DECIM; r++) begin
            cycle(0, 1, 0, 1, 0, vals[k]);
            checks++; if (out_valid !== exp_valid || out_data !== exp_data) begin errors++;
               $display("FAIL floor_neg cyc got v%b %h exp v%b %h", out_valid, out_data, exp_valid, exp_data); end
         end
      checks++; if (pulses != 1 || results[0] != want) begin errors++;
         $display("FAIL floor_neg_value got %0d pulses last %0d exp 1 of %0d", pulses, $signed(out_data), want); end
   endtask

   task automatic test_decim_ramp();
      int w0, w1;
`ifdef AVG_ROUND_EN
      w0 = 7; w1 = 19;
`else
      w0 = 6; w1 = 18;
`endif
      clear_log();
      for (int i = 0; i < 24; i++) begin
         cycle(0, 1, 0, 1, 1, i);
         checks++; if (out_valid !== exp_valid || out_data !== exp_data || out_channel !== exp_ch) begin errors++;
            $display("FAIL ramp cyc %0d got v%b ch%0d %h exp v%b ch%0d %h", i, out_valid, out_channel, out_data, exp_valid, exp_ch, exp_data); end
      end
      checks++; if (ch_pulses[1] != 2 || pulses != 2 || results[0] != w0 || results[1] != w1) begin errors++;
         $display("FAIL ramp_results got %0d pulses exp 2 with %0d,%0d", pulses, w0, w1); end
   endtask

   task automatic test_back_to_back();
      clear_log();
      for (int i = 0; i < N * DECIM; i++) begin
         cycle(0, 1, 0, 1, 0, 100);
         checks++; if (out_valid !== exp_valid || out_data !== exp_data || out_channel !== exp_ch) begin errors++;
            $display("FAIL interleave ch0 got v%b ch%0d %h exp v%b ch%0d %h", out_valid, out_channel, out_data, exp_valid, exp_ch, exp_data); end
         cycle(0, 1, 0, 1, 2, -100);
         checks++; if (out_valid !== exp_valid || out_data !== exp_data || out_channel !== exp_ch) begin errors++;
            $display("FAIL interleave ch2 got v%b ch%0d %h exp v%b ch%0d %h", out_valid, out_channel, out_data, exp_valid, exp_ch, exp_data); end
      end
      checks++; if (ch_pulses[0] != 1 || ch_pulses[2] != 1 || ch_pulses[1] != 0 || pulses != 2) begin errors++;
         $display("FAIL interleave_count got ch0=%0d ch1=%0d ch2=%0d exp 1,0,1", ch_pulses[0], ch_pulses[1], ch_pulses[2]); end
      else begin
         checks++; if (pulse_cyc[1] != pulse_cyc[0] + 1 || results[0] != 100 || results[1] != -100) begin errors++;
            $display("FAIL back_to_back got %0d,%0d at +%0d exp 100,-100 at +1", results[0], results[1], pulse_cyc[1] - pulse_cyc[0]); end
      end
   endtask

   task automatic test_reset_clear_mid(input logic use_clear, input int value);
      for (int i = 0; i < (N - 1) * DECIM + 2; i++) cycle(0, 1, 0, 1, 0, 7);
      if (use_clear) cycle(0, 1, 1, 1, 0, 7);
      else           cycle(1, 1, 0, 1, 0, 7);
      clear_log();
      checks++; if (out_data !== exp_data || out_valid !== 1'b0) begin errors++;
         $display("FAIL mid_%s hold got v%b %h exp v0 %h", use_clear ? "clear" : "reset", out_valid, out_data, exp_data); end
      for (int i = 0; i < N * DECIM; i++) begin
         cycle(0, 1, 0, 1, 0, value);
         checks++; if (out_valid !== exp_valid || out_data !== exp_data) begin errors++;
            $display("FAIL mid_%s cyc %0d got v%b %h exp v%b %h", use_clear ? "clear" : "reset", i, out_valid, out_data, exp_valid, exp_data); end
      end
      checks++; if (pulses != 1 || results[0] != value) begin errors++;
         $display("FAIL mid_%s_result got %0d pulses exp 1 of %0d", use_clear ? "clear" : "reset", pulses, value); end
   endtask

   task automatic test_drop();
      clear_log();
      for (int i = 0; i < 2 * DECIM; i++) cycle(0, 1, 0, 1, 2, 40);
      cycle(0, 1, 0, 1, 3, 9999);
      checks++; if (out_drop !== 1'b1 || out_valid !== 1'b0) begin errors++;
         $display("FAIL drop_pulse got drop%b v%b exp drop1 v0", out_drop, out_valid); end
      for (int i = 0; i < 2 * DECIM; i++) begin
         cycle(0, 1, 0, 1, 2, 40);
         checks++; if (out_drop !== exp_drop || out_valid !== exp_valid || out_data !== exp_data) begin errors++;
            $display("FAIL drop_after got d%b v%b %h exp d%b v%b %h", out_drop, out_valid, out_data, exp_drop, exp_valid, exp_data); end
      end
      checks++; if (drops != 1 || pulses != 1 || results[0] != 40 || ch_pulses[2] != 1) begin errors++;
         $display("FAIL drop_state got drops=%0d pulses=%0d exp 1,1 of 40", drops, pulses); end
   endtask

   task automatic test_enable_hold();
      clear_log();
      for (int i = 0; i < 5; i++) cycle(0, 1, 0, 1, 1, 30);
      for (int i = 0; i < 20; i++) begin
         cycle(0, 0, 0, i[0], int'($urandom_range(0, 3)), int'($urandom_range(0, 2000)));
         checks++; if (out_valid !== 1'b0 || out_drop !== 1'b0) begin errors++;
            $display("FAIL enable_low got v%b d%b exp 0 0", out_valid, out_drop); end
      end
      for (int i = 0; i < N * DECIM - 5; i++) begin
         cycle(0, 1, 0, 1, 1, 30);
         checks++; if (out_valid !== exp_valid || out_data !== exp_data) begin errors++;
            $display("FAIL enable_resume got v%b %h exp v%b %h", out_valid, out_data, exp_valid, exp_data); end
      end
      checks++; if (pulses != 1 || results[0] != 30 || ch_pulses[1] != 1) begin errors++;
         $display("FAIL enable_result got %0d pulses exp 1 of 30", pulses); end
   endtask

   task automatic test_random();
      logic signed [DATA_W-1:0] r;
      logic en, clr, v;
      int ch;
      for (int i = 0; i < 800; i++) begin
         en  = ($urandom % 8) != 0;
         clr = ($urandom % 60) == 0;
         v   = ($urandom % 4) != 0;
         ch  = int'($urandom % 4);
         if (clr && ch == 3) ch = 0;
         r = DATA_W'($urandom);
         cycle(0, en, clr, v, ch, int'(r));
         checks++; if (out_valid !== exp_valid || out_drop !== exp_drop) begin errors++;
            $display("FAIL random strobes %0d got v%b d%b exp v%b d%b", i, out_valid, out_drop, exp_valid, exp_drop); end
         checks++; if (out_data !== exp_data || out_channel !== exp_ch) begin errors++;
            $display("FAIL random result %0d got ch%0d %h exp ch%0d %h", i, out_channel, out_data, exp_ch, exp_data); end
      end
   endtask

   initial begin
      test_reset();
      test_block_average();
      test_floor_negative();
      test_decim_ramp();
      test_back_to_back();
      test_reset_clear_mid(1'b0, 50);
      test_reset_clear_mid(1'b1, 60);
      test_drop();
      test_enable_hold();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
